// File: rtl/ll_multi_queue_pkg.sv
// Shared types for the multi-channel linked-list queue: opcodes, result codes,
// chain positions, and the node, command and result records.
package linked_list_mc;

    localparam int unsigned LL_KEY_W  = 9;
    localparam int unsigned LL_ADDR_W = 10;
    localparam int unsigned LL_CH_W   = 2;

    typedef enum logic [1:0] {
        LL_INSERT,
        LL_DELETE,
        LL_DEQ
    } ll_opcode_t;

    typedef enum logic [2:0] {
        LL_INSERT_SUCCESS,
        LL_INSERT_NOT_SUCCESS_TABLE_IS_FULL,
        LL_DELETE_SUCCESS,
        LL_DELETE_NOT_SUCCESS_NO_ENTRY,
        LL_DEQUEUE_SUCCESS,
        LL_DEQUEUE_NOT_SUCCESS_NO_ENTRY
    } ll_rescode_t;

    typedef enum logic [2:0] {
        LL_NO_CHAIN,
        LL_IN_HEAD,
        LL_IN_MIDDLE,
        LL_IN_TAIL,
        LL_IN_TAIL_NO_MATCH
    } ll_chain_t;

    typedef struct packed {
        logic [LL_KEY_W-1:0]  key;
        logic [LL_ADDR_W-1:0] next_ptr;
        logic                 next_val;
    } ll_node_t;

    typedef struct packed {
        logic [LL_KEY_W-1:0] key;
        ll_opcode_t          opcode;
        logic [LL_CH_W-1:0]  channel;
    } ll_cmd_t;

    typedef struct packed {
        ll_cmd_t             cmd;
        ll_rescode_t         rescode;
        ll_chain_t           chain_state;
        logic [LL_KEY_W-1:0] key;
    } ll_result_t;

endpackage

// File: rtl/ll_node_ram.sv
// Simple dual-port node store, registered read (read-first on collisions).
// The key field can be left untouched so pointer-only updates need no read.
module ll_node_ram
    import linked_list_mc::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  wkey,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  ll_node_t              wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output ll_node_t              rdata
);

    ll_node_t mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            if (wkey)
                mem[waddr].key <= wdata.key;
            mem[waddr].next_ptr <= wdata.next_ptr;
            mem[waddr].next_val <= wdata.next_val;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/ll_multi_queue.sv
// Several singly linked FIFO lists sharing one node RAM and one free list;
// supports insert-at-tail, dequeue-from-head and delete-first-match.
module ll_multi_queue
    import linked_list_mc::*;
#(
    parameter int unsigned KEY_WIDTH  = 9,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned CHANNELS   = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  ll_cmd_t           cmd_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    output ll_result_t        result_o,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic              init_done_o,
    output logic [ADDR_WIDTH:0] free_cnt_o
);

    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;

    typedef enum logic [3:0] {
        INIT, IDLE, INS_RD_FREE, INS_WR, DEQ_RD, DEL_RD, DEL_CMP, DEL_UNLINK, RESULT
    } state_t;

    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0] head [CHANNELS];
    logic [ADDR_WIDTH-1:0] tail [CHANNELS];
    logic                  head_val [CHANNELS];
    logic [ADDR_WIDTH:0]   cnt [CHANNELS];
    logic [ADDR_WIDTH-1:0] free_head, init_ptr, cur, prev, node_q_next;
    logic                  free_val, init_done, prev_val, node_q_val;
    logic [ADDR_WIDTH:0]   free_cnt;
    ll_cmd_t               cmd_q;
    ll_rescode_t           res_code;
    ll_chain_t             res_chain;
    logic [LL_KEY_W-1:0]   res_key;

    logic                  ram_we, ram_wkey;
    logic [ADDR_WIDTH-1:0] ram_waddr, ram_raddr;
    ll_node_t              ram_wdata, ram_rdata;

    logic [CH_W-1:0] ch_i, ch_q;
    logic            accept, key_match;

    assign ch_i      = cmd_i.channel[CH_W-1:0];
    assign ch_q      = cmd_q.channel[CH_W-1:0];
    assign accept    = cmd_valid_i && cmd_ready_o;
    assign key_match = ram_rdata.key[KEY_WIDTH-1:0] == cmd_q.key[KEY_WIDTH-1:0];

    assign cmd_ready_o    = (state == IDLE) && init_done;
    assign result_valid_o = (state == RESULT);
    assign init_done_o    = init_done;
    assign free_cnt_o     = free_cnt;
    assign result_o       = '{cmd: cmd_q, rescode: res_code, chain_state: res_chain, key: res_key};

    ll_node_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk   (clk_i),
        .we    (ram_we),
        .wkey  (ram_wkey),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // At most one RAM write per state; reads are issued one state ahead of use.
    always_comb begin
        state_nx  = state;
        ram_we    = 1'b0;
        ram_wkey  = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        ram_raddr = '0;
        case (state)
            INIT: begin
                ram_we             = 1'b1;
                ram_wkey           = 1'b1;
                ram_waddr          = init_ptr;
                ram_wdata.next_ptr = LL_ADDR_W'(init_ptr + PTR_ONE);
                ram_wdata.next_val = (init_ptr != PTR_LAST);
                if (init_ptr == PTR_LAST)
                    state_nx = IDLE;
            end
            IDLE: begin
                if (cmd_i.opcode == LL_INSERT) begin
                    ram_raddr = free_head;
                    if (accept)
                        state_nx = (free_cnt == '0) ? RESULT : INS_RD_FREE;
                end else begin
                    ram_raddr = head[ch_i];
                    if (accept && !head_val[ch_i])
                        state_nx = RESULT;
                    else if (accept)
                        state_nx = (cmd_i.opcode == LL_DELETE) ? DEL_RD : DEQ_RD;
                end
            end
            INS_RD_FREE: begin
                ram_we             = head_val[ch_q];
                ram_waddr          = tail[ch_q];
                ram_wdata.next_ptr = LL_ADDR_W'(cur);
                ram_wdata.next_val = 1'b1;
                state_nx           = INS_WR;
            end
            INS_WR: begin
                ram_we        = 1'b1;
                ram_wkey      = 1'b1;
                ram_waddr     = cur;
                ram_wdata.key = cmd_q.key;
                state_nx      = RESULT;
            end
            DEQ_RD: begin
                ram_we             = 1'b1;
                ram_waddr          = cur;
                ram_wdata.next_ptr = LL_ADDR_W'(free_head);
                ram_wdata.next_val = free_val;
                state_nx           = RESULT;
            end
            DEL_RD: begin
                if (key_match) begin
                    ram_we             = 1'b1;
                    ram_waddr          = cur;
                    ram_wdata.next_ptr = LL_ADDR_W'(free_head);
                    ram_wdata.next_val = free_val;
                    state_nx           = DEL_UNLINK;
                end else begin
                    state_nx = ram_rdata.next_val ? DEL_CMP : RESULT;
                end
            end
            DEL_CMP: begin
                ram_raddr = node_q_next;
                state_nx  = DEL_RD;
            end
            DEL_UNLINK: begin
                ram_we             = prev_val;
                ram_waddr          = prev;
                ram_wdata.next_ptr = LL_ADDR_W'(node_q_next);
                ram_wdata.next_val = node_q_val;
                state_nx           = RESULT;
            end
            RESULT: begin
                if (result_ready_i)
                    state_nx = IDLE;
            end
            default: state_nx = INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= INIT;
            init_ptr    <= '0;
            init_done   <= 1'b0;
            free_head   <= '0;
            free_val    <= 1'b0;
            free_cnt    <= '0;
            cur         <= '0;
            prev        <= '0;
            prev_val    <= 1'b0;
            node_q_next <= '0;
            node_q_val  <= 1'b0;
            cmd_q       <= '0;
            res_code    <= LL_INSERT_SUCCESS;
            res_chain   <= LL_NO_CHAIN;
            res_key     <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                head[c]     <= '0;
                tail[c]     <= '0;
                head_val[c] <= 1'b0;
                cnt[c]      <= '0;
            end
        end else begin
            state <= state_nx;
            case (state)
                INIT: begin
                    init_ptr <= init_ptr + PTR_ONE;
                    if (init_ptr == PTR_LAST) begin
                        free_head <= '0;
                        free_val  <= 1'b1;
                        free_cnt  <= DEPTH;
                        init_done <= 1'b1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        cmd_q    <= cmd_i;
                        res_key  <= cmd_i.key;
                        prev_val <= 1'b0;
                        cur      <= (cmd_i.opcode == LL_INSERT) ? free_head : head[ch_i];
                        res_chain <= LL_NO_CHAIN;
                        if (cmd_i.opcode == LL_INSERT)
                            res_code <= LL_INSERT_NOT_SUCCESS_TABLE_IS_FULL;
                        else if (cmd_i.opcode == LL_DELETE)
                            res_code <= LL_DELETE_NOT_SUCCESS_NO_ENTRY;
                        else
                            res_code <= LL_DEQUEUE_NOT_SUCCESS_NO_ENTRY;
                    end
                end
                INS_RD_FREE: begin
                    free_head  <= ram_rdata.next_ptr[ADDR_WIDTH-1:0];
                    free_val   <= (free_cnt != CNT_ONE);
                    free_cnt   <= free_cnt - CNT_ONE;
                    tail[ch_q] <= cur;
                    cnt[ch_q]  <= cnt[ch_q] + CNT_ONE;
                    res_code   <= LL_INSERT_SUCCESS;
                    if (!head_val[ch_q]) begin
                        head[ch_q]     <= cur;
                        head_val[ch_q] <= 1'b1;
                        res_chain      <= LL_IN_HEAD;
                    end else begin
                        res_chain <= LL_IN_TAIL;
                    end
                end
                DEQ_RD: begin
                    res_key        <= ram_rdata.key;
                    head[ch_q]     <= ram_rdata.next_ptr[ADDR_WIDTH-1:0];
                    head_val[ch_q] <= ram_rdata.next_val && (cnt[ch_q] != CNT_ONE);
                    cnt[ch_q]      <= cnt[ch_q] - CNT_ONE;
                    free_head      <= cur;
                    free_val       <= 1'b1;
                    free_cnt       <= free_cnt + CNT_ONE;
                    res_code       <= LL_DEQUEUE_SUCCESS;
                    res_chain      <= LL_IN_HEAD;
                end
                DEL_RD: begin
                    node_q_next <= ram_rdata.next_ptr[ADDR_WIDTH-1:0];
                    node_q_val  <= ram_rdata.next_val;
                    if (!key_match && !ram_rdata.next_val)
                        res_chain <= LL_IN_TAIL_NO_MATCH;
                end
                DEL_CMP: begin
                    prev     <= cur;
                    prev_val <= 1'b1;
                    cur      <= node_q_next;
                end
                DEL_UNLINK: begin
                    if (!prev_val) begin
                        head[ch_q]     <= node_q_next;
                        head_val[ch_q] <= node_q_val;
                        res_chain      <= LL_IN_HEAD;
                    end else if (!node_q_val) begin
                        tail[ch_q] <= prev;
                        res_chain  <= LL_IN_TAIL;
                    end else begin
                        res_chain <= LL_IN_MIDDLE;
                    end
                    cnt[ch_q] <= cnt[ch_q] - CNT_ONE;
                    free_head <= cur;
                    free_val  <= 1'b1;
                    free_cnt  <= free_cnt + CNT_ONE;
                    res_code  <= LL_DELETE_SUCCESS;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ll_multi_queue.sv
// Scoreboard bench: a per-channel queue model predicts every result; a second
// instance with a 4-node RAM covers the table-full path.
module tb_ll_multi_queue;
    import linked_list_mc::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, cmd_valid, result_ready, sel;
    ll_cmd_t    cmd;
    logic       cr_a, cr_b, rv_a, rv_b, id_a, id_b;
    ll_result_t res_a, res_b;
    logic [10:0] fc_a;
    logic [2:0]  fc_b;

    ll_multi_queue #(.KEY_WIDTH(9), .ADDR_WIDTH(10), .CHANNELS(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .cmd_i(cmd), .cmd_valid_i(cmd_valid && !sel),
        .cmd_ready_o(cr_a), .result_o(res_a), .result_valid_o(rv_a),
        .result_ready_i(result_ready && !sel), .init_done_o(id_a), .free_cnt_o(fc_a));

    ll_multi_queue #(.KEY_WIDTH(9), .ADDR_WIDTH(2), .CHANNELS(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .cmd_i(cmd), .cmd_valid_i(cmd_valid && sel),
        .cmd_ready_o(cr_b), .result_o(res_b), .result_valid_o(rv_b),
        .result_ready_i(result_ready && sel), .init_done_o(id_b), .free_cnt_o(fc_b));

    logic       cmd_ready, result_valid, init_done;
    ll_result_t result;
    logic [31:0] free_cnt;
    assign cmd_ready    = sel ? cr_b : cr_a;
    assign result_valid = sel ? rv_b : rv_a;
    assign init_done    = sel ? id_b : id_a;
    assign result       = sel ? res_b : res_a;
    assign free_cnt     = sel ? 32'(fc_b) : 32'(fc_a);

    typedef struct {
        ll_opcode_t  op;
        int          ch;
        int          key;
        ll_rescode_t code;
        ll_chain_t   chain;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   mq[4][$];
    int   free_n;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic predict(input ll_opcode_t op, input int ch, input int key);
        exp_t e;
        int   k;
        e.op = op; e.ch = ch; e.key = key;
        if (op == LL_INSERT) begin
            if (free_n == 0) begin
                e.code = LL_INSERT_NOT_SUCCESS_TABLE_IS_FULL; e.chain = LL_NO_CHAIN; e.lat = 1;
            end else begin
                e.code  = LL_INSERT_SUCCESS;
                e.chain = (mq[ch].size() == 0) ? LL_IN_HEAD : LL_IN_TAIL;
                e.lat   = 3;
                mq[ch].push_back(key);
                free_n--;
            end
        end else if (op == LL_DEQ) begin
            if (mq[ch].size() == 0) begin
                e.code = LL_DEQUEUE_NOT_SUCCESS_NO_ENTRY; e.chain = LL_NO_CHAIN; e.lat = 1;
            end else begin
                e.code = LL_DEQUEUE_SUCCESS; e.chain = LL_IN_HEAD; e.lat = 2;
                e.key  = mq[ch].pop_front();
                free_n++;
            end
        end else begin
            k = -1;
            for (int i = 0; i < mq[ch].size(); i++)
                if (k < 0 && mq[ch][i] == key) k = i;
            if (mq[ch].size() == 0) begin
                e.code = LL_DELETE_NOT_SUCCESS_NO_ENTRY; e.chain = LL_NO_CHAIN; e.lat = 1;
            end else if (k < 0) begin
                e.code = LL_DELETE_NOT_SUCCESS_NO_ENTRY; e.chain = LL_IN_TAIL_NO_MATCH;
                e.lat  = 2 * mq[ch].size();
            end else begin
                e.code  = LL_DELETE_SUCCESS;
                e.chain = (k == 0) ? LL_IN_HEAD :
                          (k == mq[ch].size() - 1) ? LL_IN_TAIL : LL_IN_MIDDLE;
                e.lat   = 2 * (k + 1) + 1;
                mq[ch].delete(k);
                free_n++;
            end
        end
        sb.push_back(e);
    endtask

    task automatic drive_cmd(input ll_opcode_t op, input int ch, input int key);
        int n;
        cmd.key = key[8:0]; cmd.opcode = op; cmd.channel = ch[1:0];
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        check("accept", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_cmd(input ll_opcode_t op, input int ch, input int key, input int hold);
        exp_t e;
        int   lat;
        predict(op, ch, key);
        result_ready = (hold == 0);
        drive_cmd(op, ch, key);
        lat = 1;
        while (!result_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", result_valid, 1);
            check("hold_key", 32'(result.key), sb[0].key);
            check("hold_code", 32'(result.rescode), 32'(sb[0].code));
            check("hold_ready_low", cmd_ready, 0);
            @(posedge clk); #1;
        end
        result_ready = 1'b1;
        e = sb.pop_front();
        check("latency", lat, e.lat);
        check("rescode", 32'(result.rescode), 32'(e.code));
        check("chain", 32'(result.chain_state), 32'(e.chain));
        check("key", 32'(result.key), e.key);
        check("echo_op", 32'(result.cmd.opcode), 32'(e.op));
        check("echo_ch", 32'(result.cmd.channel), e.ch);
        @(posedge clk); #1;
        check("valid_drop", result_valid, 0);
    endtask

    task automatic wait_init(input int depth, input int exp_cycles);
        int n;
        n = 0;
        while (!init_done && n < depth + 100) begin
            @(posedge clk); #1; n++;
        end
        if (exp_cycles >= 0) check("init_cycles", n, exp_cycles);
        check("init_done", init_done, 1);
        check("init_free_cnt", free_cnt, depth);
        check("init_ready", cmd_ready, 1);
        for (int c = 0; c < 4; c++) mq[c].delete();
        free_n = depth;
    endtask

    task automatic do_reset(input int depth);
        rst = 1'b1; cmd_valid = 1'b0; result_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_init_done", init_done, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        wait_init(depth, depth);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        sel = 1'b0; cmd = '0;
        do_reset(1024);

        // FIFO order on one channel, then empty dequeue
        do_cmd(LL_INSERT, 2, 5, 0);
        do_cmd(LL_INSERT, 2, 7, 0);
        do_cmd(LL_INSERT, 2, 9, 0);
        repeat (4) do_cmd(LL_DEQ, 2, 0, 0);

        // middle / tail deletion and tail repair
        do_cmd(LL_INSERT, 0, 1, 0);
        do_cmd(LL_INSERT, 0, 2, 0);
        do_cmd(LL_INSERT, 0, 3, 0);
        do_cmd(LL_DELETE, 0, 2, 0);
        do_cmd(LL_DELETE, 0, 3, 0);
        do_cmd(LL_INSERT, 0, 4, 0);
        do_cmd(LL_DEQ, 0, 0, 0);
        do_cmd(LL_DEQ, 0, 0, 0);

        // channel isolation and empty-channel delete
        do_cmd(LL_INSERT, 1, 8, 0);
        do_cmd(LL_INSERT, 3, 8, 0);
        do_cmd(LL_DELETE, 1, 8, 0);
        do_cmd(LL_DEQ, 3, 0, 0);
        do_cmd(LL_DELETE, 0, 8, 0);
        do_cmd(LL_DELETE, 2, 6, 0);

        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 2);
            do_cmd((r == 0) ? LL_INSERT : (r == 1) ? LL_DELETE : LL_DEQ,
                   $urandom_range(0, 3), $urandom_range(0, 5), 0);
        end
        check("free_cnt_model", free_cnt, free_n);

        // back-pressure on the result
        do_cmd(LL_INSERT, 1, 21, 10);

        // reset during a DELETE walk
        for (int c = 0; c < 4; c++)
            while (mq[c].size() != 0) do_cmd(LL_DEQ, c, 0, 0);
        do_cmd(LL_INSERT, 1, 11, 0);
        do_cmd(LL_INSERT, 1, 12, 0);
        do_cmd(LL_INSERT, 1, 13, 0);
        drive_cmd(LL_DELETE, 1, 13);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_valid", result_valid, 0);
        check("abort_init_done", init_done, 0);
        check("abort_ready", cmd_ready, 0);
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (result_valid) seen = 1;
        end
        check("abort_no_result", seen, 0);
        wait_init(1024, -1);
        do_cmd(LL_DEQ, 1, 0, 0);

        // 4-node table: fill, overflow, recover
        sel = 1'b1;
        do_reset(4);
        for (int i = 0; i < 5; i++) do_cmd(LL_INSERT, i % 4, 30 + i, 0);
        check("full_free_cnt", free_cnt, 0);
        do_cmd(LL_DEQ, 0, 0, 0);
        do_cmd(LL_INSERT, 2, 40, 0);
        do_cmd(LL_INSERT, 3, 41, 0);
        check("small_free_cnt", free_cnt, free_n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
